spart_rx: RTL and testbench

Receive half of the SPART serial port. Recovers 8N1 frames from the asynchronous rxd line (1 start bit low, 8 data bits LSB first, 1 stop bit high) by oversampling with a 16x baud enable from the baud-rate generator. It presents the received byte with a receive-data-available flag (rda) plus framing and overrun error flags to the SPART bus interface, which acknowledges with clr_rda.

---
 rtl/spart_rx.sv | 145 ++++++++++++++
 tb/tb_spart_rx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_rx.sv
// SPART receiver: recovers 8N1 frames from the asynchronous rxd line using a
// 16x (OVERSAMPLE) baud enable, and presents the byte with rda/frm_err/ovr_err
// to the bus interface, which acknowledges with clr_rda.
module spart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en16,
  input  logic       rxd,
  input  logic       clr_rda,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       frm_err,
  output logic       ovr_err
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  // The detection tick already counts as tick 0 of the start bit, so the
  // mid-start sample happens when the counter (started one tick later) hits
  // OVERSAMPLE/2-2, i.e. OVERSAMPLE/2-1 ticks after detection.
  localparam logic [TW-1:0] START_LAST = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [TW-1:0] BIT_LAST   = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shft_q, shft_d;
  logic          load;

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // Metastability synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  // Frame FSM state, tick/bit counters and shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shft_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shft_q  <= shft_d;
    end
  end

  // Next-state logic; everything advances only on en16 ticks.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shft_d  = shft_q;
    load    = 1'b0;
    if (en16) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == START_LAST) begin
            tick_d = '0;
            bit_d  = '0;
            state_d = rxd_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_q == BIT_LAST) begin
            shft_d = {rxd_s, shft_q[7:1]};
            tick_d = '0;
            bit_d  = bit_q + 1'b1;
            if (bit_q == 3'd7) begin
              state_d = STOP;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_q == BIT_LAST) begin
            load    = 1'b1;
            tick_d  = '0;
            state_d = rxd_s ? IDLE : BRK;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        BRK: begin
          if (rxd_s) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Bus-facing registers; a byte load takes priority over clr_rda.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data <= 8'h00;
      rda     <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else if (load) begin
      rx_data <= shft_q;
      rda     <= 1'b1;
      frm_err <= ~rxd_s;
      ovr_err <= rda & ~clr_rda;
    end else if (clr_rda) begin
      rda     <= 1'b0;
      ovr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: frame-level model of the receiver's
// bus-facing registers, checked every clock, plus literal spot checks.
module tb_spart_rx;

  logic       clk;
  logic       rst;
  logic       en16;
  logic       rxd;
  logic       clr_rda;
  logic [7:0] rx_data;
  logic       rda;
  logic       frm_err;
  logic       ovr_err;

  int tests_run = 0;
  int failures  = 0;

  logic [7:0] exp_data;
  logic       exp_rda;
  logic       exp_frm;
  logic       exp_ovr;
  logic       cmp_en;
  logic       cmp_hold;

  int tick_no   = 0;
  int fall_tick = 0;
  int rise_tick = -1;
  logic rda_prev = 1'b0;

  spart_rx #(
    .OVERSAMPLE(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en16   (en16),
    .rxd    (rxd),
    .clr_rda(clr_rda),
    .rx_data(rx_data),
    .rda    (rda),
    .frm_err(frm_err),
    .ovr_err(ovr_err)
  );

  // 100 MHz system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud enable: one pulse every 4 clocks, changed on the falling edge.
  initial begin
    en16 = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      en16 = 1'b1;
      @(negedge clk);
      en16 = 1'b0;
    end
  end

  // Global en16 tick counter used for latency measurement.
  always @(posedge clk) begin
    if (en16) tick_no <= tick_no + 1;
  end

  // Record the tick on which rda rises.
  always @(negedge clk) begin
    if (rda && !rda_prev) rise_tick <= tick_no;
    rda_prev <= rda;
  end

  // Watchdog so the run always ends.
  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Continuous compare of the DUT against the model, outside load windows.
  always @(negedge clk) begin
    if (cmp_en && !cmp_hold) begin
      checkOutput("cyc_rx_data", rx_data, exp_data);
      checkOutput("cyc_rda", {7'd0, rda}, {7'd0, exp_rda});
      checkOutput("cyc_frm_err", {7'd0, frm_err}, {7'd0, exp_frm});
      checkOutput("cyc_ovr_err", {7'd0, ovr_err}, {7'd0, exp_ovr});
    end
  end

  task automatic modelReset();
    exp_data = 8'h00;
    exp_rda  = 1'b0;
    exp_frm  = 1'b0;
    exp_ovr  = 1'b0;
  endtask

  // A byte arrives: overrun if the previous one was unread and not being
  // acknowledged on the same clock.
  task automatic modelLoad(input logic [7:0] b, input logic stop_val,
                           input logic clr_same);
    exp_ovr  = exp_rda && !clr_same;
    exp_data = b;
    exp_rda  = 1'b1;
    exp_frm  = !stop_val;
  endtask

  task automatic waitTick();
    do @(posedge clk); while (en16 !== 1'b1);
    #1;
  endtask

  task automatic waitTicks(input int n);
    for (int i = 0; i < n; i++) waitTick();
  endtask

  task automatic pulseClr();
    @(negedge clk);
    clr_rda = 1'b1;
    @(posedge clk);
    #1;
    clr_rda = 1'b0;
    exp_rda = 1'b0;
    exp_ovr = 1'b0;
  endtask

  // Send one frame (16 ticks per bit) after 40 idle ticks; optionally keep
  // the line low after the stop bit and/or acknowledge on the load clock.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_val,
                               input int extra_low, input logic clr_at_load);
    int bit_idx;
    rxd = 1'b1;
    waitTicks(40);
    fall_tick = tick_no;
    for (int t = 0; t < 160; t++) begin
      bit_idx = t / 16;
      if (bit_idx == 0) rxd = 1'b0;
      else if (bit_idx <= 8) rxd = b[bit_idx-1];
      else rxd = stop_val;
      if (t == 148) cmp_hold = 1'b1;
      if (clr_at_load && t == 151) begin
        repeat (3) @(posedge clk);
        #1;
        clr_rda = 1'b1;
        @(posedge clk);
        #1;
        clr_rda = 1'b0;
      end else begin
        waitTick();
      end
      if (t + 1 == 156) begin
        modelLoad(b, stop_val, clr_at_load);
        cmp_hold = 1'b0;
      end
    end
    if (extra_low > 0) begin
      rxd = 1'b0;
      waitTicks(extra_low);
    end
    rxd = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    rxd      = 1'b1;
    clr_rda  = 1'b0;
    cmp_en   = 1'b0;
    cmp_hold = 1'b0;
    modelReset();

    // Reset state.
    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_rda", {7'd0, rda}, 8'h00);
    checkOutput("reset_frm_err", {7'd0, frm_err}, 8'h00);
    checkOutput("reset_ovr_err", {7'd0, ovr_err}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;

    // Good frame 0xA5 and its latency.
    applyStimulus(8'hA5, 1'b1, 0, 1'b0);
    checkOutput("a5_rx_data", rx_data, 8'hA5);
    checkOutput("a5_rda", {7'd0, rda}, 8'h01);
    checkOutput("a5_frm_err", {7'd0, frm_err}, 8'h00);
    checkOutput("a5_ovr_err", {7'd0, ovr_err}, 8'h00);
    tests_run++;
    if (rise_tick < 0 || (rise_tick - fall_tick) < 150 ||
        (rise_tick - fall_tick) > 152) begin
      failures++;
      $display("[TB] FAIL a5_latency: rda rose %0d ticks after fall, expected 150..152",
               rise_tick - fall_tick);
    end
    pulseClr();
    #1;
    checkOutput("a5_clr_rda", {7'd0, rda}, 8'h00);

    // Start-bit glitch, then a good 0x3C.
    rxd = 1'b1;
    waitTicks(40);
    rxd = 1'b0;
    waitTicks(3);
    rxd = 1'b1;
    waitTicks(200);
    checkOutput("glitch_rda", {7'd0, rda}, 8'h00);
    applyStimulus(8'h3C, 1'b1, 0, 1'b0);
    checkOutput("glitch_next_rx_data", rx_data, 8'h3C);
    pulseClr();

    // Framing error with line held low afterwards: exactly one byte.
    applyStimulus(8'h3C, 1'b0, 50, 1'b0);
    waitTicks(60);
    checkOutput("brk_rx_data", rx_data, 8'h3C);
    checkOutput("brk_frm_err", {7'd0, frm_err}, 8'h01);
    checkOutput("brk_ovr_err", {7'd0, ovr_err}, 8'h00);
    pulseClr();
    #1;
    checkOutput("brk_frm_after_clr", {7'd0, frm_err}, 8'h01);
    applyStimulus(8'h81, 1'b1, 0, 1'b0);
    checkOutput("brk_next_rx_data", rx_data, 8'h81);
    checkOutput("brk_next_frm_err", {7'd0, frm_err}, 8'h00);
    pulseClr();

    // Overrun: two bytes without acknowledge.
    applyStimulus(8'h11, 1'b1, 0, 1'b0);
    applyStimulus(8'h22, 1'b1, 0, 1'b0);
    checkOutput("ovr_rx_data", rx_data, 8'h22);
    checkOutput("ovr_ovr_err", {7'd0, ovr_err}, 8'h01);
    pulseClr();
    #1;
    checkOutput("ovr_clr_rda", {7'd0, rda}, 8'h00);
    checkOutput("ovr_clr_ovr", {7'd0, ovr_err}, 8'h00);

    // Acknowledge on the very clock of the next load: load wins.
    applyStimulus(8'h33, 1'b1, 0, 1'b0);
    applyStimulus(8'h7E, 1'b1, 0, 1'b1);
    checkOutput("coinc_rx_data", rx_data, 8'h7E);
    checkOutput("coinc_rda", {7'd0, rda}, 8'h01);
    checkOutput("coinc_ovr_err", {7'd0, ovr_err}, 8'h00);
    pulseClr();

    // Load one byte so outputs are non-zero, then reset mid-frame of 0xF0.
    applyStimulus(8'hC3, 1'b0, 0, 1'b0);
    rxd = 1'b1;
    waitTicks(40);
    rxd = 1'b0;
    waitTicks(16);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b0;
      waitTicks(16);
    end
    rxd = 1'b1;
    waitTicks(8);
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("midrst_rx_data", rx_data, 8'h00);
    checkOutput("midrst_rda", {7'd0, rda}, 8'h00);
    checkOutput("midrst_frm_err", {7'd0, frm_err}, 8'h00);
    checkOutput("midrst_ovr_err", {7'd0, ovr_err}, 8'h00);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(8'h5A, 1'b1, 0, 1'b0);
    checkOutput("post_rst_rx_data", rx_data, 8'h5A);
    checkOutput("post_rst_rda", {7'd0, rda}, 8'h01);
    checkOutput("post_rst_frm_err", {7'd0, frm_err}, 8'h00);
    checkOutput("post_rst_ovr_err", {7'd0, ovr_err}, 8'h00);
    waitTicks(10);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
